// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared definitions for the router input-port logic.
//   - Default virtual-channel count, per-VC queue depth exponent and flit width.
//   - VC index type and flit type sized from those defaults.
//   - calc_vc_w(): width of a VC index for a given VC count (at least 1 bit).
// -----------------------------------------------------------------------------
package noc_pkg;

    localparam int NUM_VC_DEF     = 4;
    localparam int ADDR_WIDTH_DEF = 3;
    localparam int DATA_WIDTH_DEF = 64;

    // A single-VC configuration still needs a 1-bit index port.
    function automatic int calc_vc_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int VC_W_DEF = calc_vc_w(NUM_VC_DEF);

    typedef logic [VC_W_DEF-1:0]       vc_idx_t;
    typedef logic [DATA_WIDTH_DEF-1:0] flit_t;

endpackage : noc_pkg

// File: rtl/vc_fifo_slice.sv
// -----------------------------------------------------------------------------
// vc_fifo_slice
// One first-word-fall-through queue of 2**ADDR_WIDTH entries. The caller only
// asserts push/pop for operations it has already accepted, so this block does
// no overflow/underflow protection of its own.
//
// Ports:
//   clk    in   clock
//   reset  in   asynchronous, active-high reset
//   push   in   store din at the tail (accepted write)
//   pop    in   discard the head entry (accepted read)
//   din    in   DATA_WIDTH  write data
//   dout   out  DATA_WIDTH  current head entry (valid while !empty)
//   count  out  ADDR_WIDTH+1  occupancy, 0..DEPTH
//   empty  out  count == 0
//   full   out  count == DEPTH
// -----------------------------------------------------------------------------
module vc_fifo_slice #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  empty,
    output logic                  full
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int CNT_W = ADDR_WIDTH + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;

    always_comb begin
        // NOTE: every target gets a default first so no path leaves it unassigned, which would infer a latch.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end

        // Pointers wrap modulo DEPTH on their own; simultaneous push+pop
        // (including when full) leaves the occupancy unchanged.
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage is reset too, so dout reads as zero after reset rather than stale data from before it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Fall-through head and status come straight from registered state.
    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

endmodule : vc_fifo_slice

// File: rtl/vc_input_buffer.sv
// -----------------------------------------------------------------------------
// vc_input_buffer
// Router input-port buffer holding NUM_VC independent FWFT queues that share a
// single write port and have one read port each. Produces per-VC status, a
// registered credit pulse per accepted pop, and sticky protocol error flags.
//
// Ports:
//   clk            in   clock
//   reset          in   asynchronous, active-high reset
//   push           in   write request
//   push_vc        in   VC_W                      target VC of the write
//   din            in   DATA_WIDTH                write flit
//   pop            in   NUM_VC                    per-VC read request
//   dout           out  NUM_VC*DATA_WIDTH         head flit per VC, VC v at [v*DATA_WIDTH +: DATA_WIDTH]
//   empty          out  NUM_VC                    VC holds no entries
//   full           out  NUM_VC                    VC holds DEPTH entries
//   almost_full    out  NUM_VC                    count >= AFULL_LEVEL
//   count          out  NUM_VC*(ADDR_WIDTH+1)     occupancy per VC
//   credit         out  NUM_VC                    one-cycle pulse after each accepted pop
//   overflow_err   out  sticky: a push was dropped
//   underflow_err  out  sticky: a pop on an empty VC was ignored
// -----------------------------------------------------------------------------
module vc_input_buffer
    import noc_pkg::*;
#(
    parameter int  NUM_VC      = NUM_VC_DEF,
    parameter int  ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int  DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int  AFULL_LEVEL = 2 ** ADDR_WIDTH - 1,
    localparam int VC_W        = calc_vc_w(NUM_VC),
    localparam int CNT_W       = ADDR_WIDTH + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic [VC_W-1:0]              push_vc,
    input  logic [DATA_WIDTH-1:0]        din,
    input  logic [NUM_VC-1:0]            pop,
    output logic [NUM_VC*DATA_WIDTH-1:0] dout,
    output logic [NUM_VC-1:0]            empty,
    output logic [NUM_VC-1:0]            full,
    output logic [NUM_VC-1:0]            almost_full,
    output logic [NUM_VC*CNT_W-1:0]      count,
    output logic [NUM_VC-1:0]            credit,
    output logic                         overflow_err,
    output logic                         underflow_err
);

    logic [NUM_VC-1:0] slice_empty;
    logic [NUM_VC-1:0] slice_full;
    logic [NUM_VC-1:0] slice_push;
    logic [NUM_VC-1:0] pop_ok;
    logic              push_target_ok;
    logic              push_ok;

    logic [NUM_VC-1:0] credit_q, credit_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    // Guards non-power-of-two VC counts, where push_vc can name a missing VC.
    assign push_target_ok = ({1'b0, push_vc} < (VC_W + 1)'(NUM_VC));

    always_comb begin
        // There is no bypass: a pop on an empty VC is ignored even if the
        // same cycle pushes into it.
        pop_ok = pop & ~slice_empty;

        // A full VC still accepts a write when its head leaves in the same cycle.
        push_ok = push && push_target_ok &&
                  (!slice_full[push_vc] || pop_ok[push_vc]);

        for (int v = 0; v < NUM_VC; v++) begin
            slice_push[v] = push_ok && (push_vc == VC_W'(v));
        end

        credit_d    = pop_ok;
        overflow_d  = overflow_q | (push & ~push_ok);
        underflow_d = underflow_q | (|(pop & slice_empty));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            credit_q    <= credit_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    for (genvar v = 0; v < NUM_VC; v++) begin : g_vc
        vc_fifo_slice #(
            .ADDR_WIDTH (ADDR_WIDTH),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_slice (
            .clk   (clk),
            .reset (reset),
            .push  (slice_push[v]),
            .pop   (pop_ok[v]),
            .din   (din),
            .dout  (dout[v*DATA_WIDTH +: DATA_WIDTH]),
            .count (count[v*CNT_W +: CNT_W]),
            .empty (slice_empty[v]),
            .full  (slice_full[v])
        );

        assign almost_full[v] = (count[v*CNT_W +: CNT_W] >= CNT_W'(AFULL_LEVEL));
    end

    assign empty         = slice_empty;
    assign full          = slice_full;
    assign credit        = credit_q;
    assign overflow_err  = overflow_q;
    assign underflow_err = underflow_q;

endmodule : vc_input_buffer

// File: tb/tb_vc_input_buffer.sv
// -----------------------------------------------------------------------------
// tb_vc_input_buffer
// Self-checking bench for vc_input_buffer. A queue-per-VC reference model
// predicts the post-edge state for every issued cycle; a separate monitor
// pops those predictions and compares them with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_vc_input_buffer;

    localparam int NUM_VC = 4;
    localparam int ADDR_W = 3;
    localparam int DW     = 64;
    localparam int DEPTH  = 8;
    localparam int CW     = ADDR_W + 1;
    localparam int VC_W   = 2;
    localparam int AFULL  = 7;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   push;
    logic [VC_W-1:0]        push_vc;
    logic [DW-1:0]          din;
    logic [NUM_VC-1:0]      pop;
    logic [NUM_VC*DW-1:0]   dout;
    logic [NUM_VC-1:0]      empty;
    logic [NUM_VC-1:0]      full;
    logic [NUM_VC-1:0]      almost_full;
    logic [NUM_VC*CW-1:0]   count;
    logic [NUM_VC-1:0]      credit;
    logic                   overflow_err;
    logic                   underflow_err;

    always #5 clk = ~clk;

    vc_input_buffer #(
        .NUM_VC      (NUM_VC),
        .ADDR_WIDTH  (ADDR_W),
        .DATA_WIDTH  (DW),
        .AFULL_LEVEL (AFULL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .push          (push),
        .push_vc       (push_vc),
        .din           (din),
        .pop           (pop),
        .dout          (dout),
        .empty         (empty),
        .full          (full),
        .almost_full   (almost_full),
        .count         (count),
        .credit        (credit),
        .overflow_err  (overflow_err),
        .underflow_err (underflow_err)
    );

    typedef struct packed {
        logic [NUM_VC-1:0][CW-1:0] cnt;
        logic [NUM_VC-1:0][DW-1:0] head;
        logic [NUM_VC-1:0]         credit;
        logic                      ovf;
        logic                      unf;
    } exp_t;

    exp_t          sb [$];
    logic [DW-1:0] mq [NUM_VC][$];
    logic          m_ovf;
    logic          m_unf;
    bit            mon_en;
    int            checks;
    int            errors;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Issue one cycle of stimulus at the falling edge, predict its effect,
    // and return at the next falling edge.
    task automatic step(input logic p, input logic [VC_W-1:0] vc,
                        input logic [DW-1:0] d, input logic [NUM_VC-1:0] pp);
        exp_t              e;
        logic [NUM_VC-1:0] pok;
        logic              pus;
        push    = p;
        push_vc = vc;
        din     = d;
        pop     = pp;
        for (int v = 0; v < NUM_VC; v++) begin
            pok[v] = pp[v] && (mq[v].size() > 0);
            if (pp[v] && mq[v].size() == 0) m_unf = 1'b1;
        end
        pus = p && (int'(vc) < NUM_VC) && ((mq[vc].size() < DEPTH) || pok[vc]);
        if (p && !pus) m_ovf = 1'b1;
        for (int v = 0; v < NUM_VC; v++) begin
            if (pok[v]) void'(mq[v].pop_front());
        end
        if (pus) mq[vc].push_back(d);
        e.credit = pok;
        e.ovf    = m_ovf;
        e.unf    = m_unf;
        for (int v = 0; v < NUM_VC; v++) begin
            e.cnt[v]  = CW'(mq[v].size());
            e.head[v] = (mq[v].size() > 0) ? mq[v][0] : '0;
        end
        sb.push_back(e);
        @(negedge clk);
    endtask

    function automatic logic [CW-1:0] cnt_of(input int v);
        return count[v*CW +: CW];
    endfunction

    function automatic logic [DW-1:0] dout_of(input int v);
        return dout[v*DW +: DW];
    endfunction

    // Monitor: one prediction per clock while enabled.
    exp_t mon_e;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (mon_en) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard_sync: no prediction queued at time %0t", $time);
                end else begin
                    mon_e = sb.pop_front();
                    for (int v = 0; v < NUM_VC; v++) begin
                        check($sformatf("count_vc%0d", v), cnt_of(v), mon_e.cnt[v]);
                        check($sformatf("empty_vc%0d", v), empty[v], mon_e.cnt[v] == 0);
                        check($sformatf("full_vc%0d", v), full[v], mon_e.cnt[v] == DEPTH);
                        check($sformatf("afull_vc%0d", v), almost_full[v], mon_e.cnt[v] >= AFULL);
                        if (!empty[v] && mon_e.cnt[v] != 0)
                            check($sformatf("head_vc%0d", v), dout_of(v), mon_e.head[v]);
                    end
                    check("credit", credit, mon_e.credit);
                    check("overflow_err", overflow_err, mon_e.ovf);
                    check("underflow_err", underflow_err, mon_e.unf);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        push    = 1'b0;
        push_vc = '0;
        din     = '0;
        pop     = '0;
        mon_en  = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        checks  = 0;
        errors  = 0;

        repeat (2) @(negedge clk);
        check("rst_count", count, '0);
        check("rst_empty", empty, 4'hF);
        check("rst_full", full, '0);
        check("rst_afull", almost_full, '0);
        check("rst_credit", credit, '0);
        check("rst_errs", {overflow_err, underflow_err}, '0);
        check("rst_dout_zero", 64'(|dout), '0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Three pushes into VC2.
        step(1'b1, 2'd2, 64'hA1, 4'b0000);
        step(1'b1, 2'd2, 64'hA2, 4'b0000);
        step(1'b1, 2'd2, 64'hA3, 4'b0000);
        check("t1_count2", cnt_of(2), 4'd3);
        check("t1_dout2", dout_of(2), 64'hA1);
        check("t1_empty", empty, 4'b1011);
        check("t1_count0", cnt_of(0), 4'd0);
        repeat (3) step(1'b0, 2'd0, '0, 4'b0100);

        // Fill VC0 to DEPTH, then one push too many.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 2'd0, 64'h100 + 64'(i), 4'b0000);
            if (i == 5) check("t2_afull_after6", almost_full[0], 1'b0);
            if (i == 6) check("t2_afull_after7", almost_full[0], 1'b1);
        end
        step(1'b1, 2'd0, 64'h1FF, 4'b0000);
        check("t2_full0", full[0], 1'b1);
        check("t2_count0", cnt_of(0), 4'd8);
        check("t2_overflow", overflow_err, 1'b1);

        // Full VC0 with simultaneous push and pop.
        step(1'b1, 2'd0, 64'h55, 4'b0001);
        check("t3_count0", cnt_of(0), 4'd8);
        check("t3_credit_pulse", credit, 4'b0001);
        step(1'b0, 2'd0, '0, 4'b0000);
        check("t3_credit_gone", credit, 4'b0000);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) check("t3_last_is_55", dout_of(0), 64'h55);
            step(1'b0, 2'd0, '0, 4'b0001);
        end
        repeat (3) begin
            for (int i = 0; i < DEPTH; i++) step(1'b1, 2'd0, {$urandom, $urandom}, 4'b0000);
            for (int i = 0; i < DEPTH; i++) step(1'b0, 2'd0, '0, 4'b0001);
        end

        // Pop every VC with only VC1 and VC3 holding data.
        check("t4_no_underflow_yet", underflow_err, 1'b0);
        step(1'b1, 2'd1, 64'hB1, 4'b0000);
        step(1'b1, 2'd3, 64'hB3, 4'b0000);
        step(1'b0, 2'd0, '0, 4'b1111);
        check("t4_credit", credit, 4'b1010);
        check("t4_underflow", underflow_err, 1'b1);
        check("t4_count0", cnt_of(0), 4'd0);
        check("t4_count2", cnt_of(2), 4'd0);

        // Push and pop on an empty VC3 in the same cycle.
        step(1'b1, 2'd3, 64'hC3, 4'b1000);
        check("t5_count3", cnt_of(3), 4'd1);
        check("t5_no_credit", credit, 4'b0000);
        check("t5_dout3", dout_of(3), 64'hC3);
        step(1'b0, 2'd0, '0, 4'b1000);

        // Reset in the middle of a VC1 burst with a credit pulse in flight.
        for (int i = 0; i < 5; i++) step(1'b1, 2'd1, 64'hD0 + 64'(i), 4'b0000);
        step(1'b1, 2'd1, 64'hD5, 4'b0010);
        mon_en = 1'b0;
        push   = 1'b0;
        pop    = '0;
        #2 reset = 1'b1;
        #1;
        check("t6_count", count, '0);
        check("t6_empty", empty, 4'hF);
        check("t6_full", full, '0);
        check("t6_afull", almost_full, '0);
        check("t6_credit", credit, '0);
        check("t6_errs", {overflow_err, underflow_err}, '0);
        check("t6_dout_zero", 64'(|dout), '0);
        @(negedge clk);
        reset = 1'b0;
        for (int v = 0; v < NUM_VC; v++) mq[v].delete();
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        mon_en = 1'b1;
        step(1'b0, 2'd0, '0, 4'b0000);
        check("t6_no_credit_after", credit, 4'b0000);
        step(1'b1, 2'd1, 64'hE0, 4'b0000);
        check("t6_resume_dout1", dout_of(1), 64'hE0);
        step(1'b0, 2'd0, '0, 4'b0010);
        check("t6_resume_credit", credit, 4'b0010);

        // Randomised traffic: a fill-biased phase then a drain-biased phase.
        for (int phase = 0; phase < 2; phase++) begin
            for (int n = 0; n < 800; n++) begin
                logic [NUM_VC-1:0] pp;
                for (int v = 0; v < NUM_VC; v++)
                    pp[v] = (phase == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 0);
                step($urandom_range(0, 3) != 0, VC_W'($urandom_range(0, NUM_VC - 1)),
                     {$urandom, $urandom}, pp);
            end
        end
        step(1'b0, 2'd0, '0, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_vc_input_buffer

// File: doc/vc_input_buffer.md
Name: vc_input_buffer

Overview:
Multi-virtual-channel input buffer for a router input port; successor to the single-queue flit FIFO.
- Holds NUM_VC independent first-word-fall-through queues sharing one write port, each with its own read port.
- Per-VC occupancy, full/almost-full status and registered credit-return pulses for the upstream credit counter.
- Sticky overflow/underflow error flags for protocol checking.

Parameters:
NUM_VC, 4, number of virtual channels (>=1)
ADDR_WIDTH, 3, log2 of per-VC queue depth
DATA_WIDTH, 64, flit width in bits
AFULL_LEVEL, 2**ADDR_WIDTH-1, occupancy at or above which almost_full[v] asserts
DEPTH (derived, not overridable), 2**ADDR_WIDTH, entries per VC
VC_W (derived), max(1,$clog2(NUM_VC)), VC index width

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
push  in  1  write request
push_vc  in  VC_W  target VC of write
din  in  DATA_WIDTH  write flit
pop  in  NUM_VC  per-VC read request; any combination allowed
dout  out  NUM_VC*DATA_WIDTH  head flit of each VC; VC v at bits [v*DATA_WIDTH +: DATA_WIDTH]
empty  out  NUM_VC  VC v holds 0 entries
full  out  NUM_VC  VC v holds DEPTH entries
almost_full  out  NUM_VC  count[v] >= AFULL_LEVEL
count  out  NUM_VC*(ADDR_WIDTH+1)  occupancy per VC, 0..DEPTH inclusive
credit  out  NUM_VC  one-cycle pulse per accepted pop
overflow_err  out  1  sticky: push dropped
underflow_err  out  1  sticky: pop ignored

Behaviour:
- Reset (async assert, sync-to-clk deassert use): count=0, empty=all 1, full=0, almost_full=0, credit=0, both errors=0, storage and pointers cleared, dout=0.
- FWFT: dout[v] is the oldest entry combinationally; valid only while !empty[v]. It updates the cycle after a pop or after the first push into an empty VC.
- Occupancy counter is ADDR_WIDTH+1 bits, so DEPTH is representable. Read/write pointers are ADDR_WIDTH bits and wrap modulo DEPTH naturally.
- Push accepted if push && push_vc<NUM_VC && (!full[push_vc] || pop[push_vc]). Otherwise it is dropped: storage unchanged, overflow_err set.
- Pop on VC v accepted iff pop[v] && !empty[v]. A pop on an empty VC is ignored and sets underflow_err. This applies even if a same-cycle push targets that VC, because no bypass path exists.
- Same-VC push+pop, both accepted: count unchanged, both pointers advance. This includes the full case.
- Pops on different VCs in the same cycle are independent.
- credit[v] registered: high exactly one cycle after each accepted pop on v, low otherwise.
- Status outputs are derived from registered count. No combinational path from push/pop to status or dout within a cycle.
- Error flags clear only on reset.
- Reset asserted mid-traffic: all contents discarded immediately; no credit pulses issued for discarded flits.

Decomposition:
- noc_pkg: VC index type, flit type sized by DATA_WIDTH, default NUM_VC/ADDR_WIDTH constants.
- Sub-module vc_fifo_slice: one FWFT queue with ADDR_WIDTH/DATA_WIDTH parameters. Ports clk, reset, push, pop, din, dout, count, empty, full. It performs only accepted operations.
- Top: generate loop of NUM_VC slices, plus write decode, accept logic, credit registers and error flags.

Test Plan:
1. Reset, then push 0xA1,0xA2,0xA3 to VC2, one per cycle, no pops -> count[2]=3, dout[2]=0xA1, empty=4'b1011, other counts 0.
2. Fill VC0 with 8 flits, then push a 9th with no pop -> full[0]=1, count[0]=8, 9th dropped, overflow_err=1; almost_full[0] first rises after the 7th push.
3. VC0 full; push 0x55 to VC0 with pop[0]=1 -> count[0] stays 8, credit[0] pulses next cycle only; after draining, 0x55 emerges last. Pointers wrap correctly over 3 full fill/drain cycles.
4. Pop=4'b1111 with only VC1 and VC3 non-empty -> credit=4'b1010 next cycle, underflow_err=1, VC0/VC2 counts remain 0.
5. Push to empty VC3 with pop[3]=1 same cycle -> flit stored, count[3]=1, no credit, underflow_err=1.
6. Assert reset mid-burst with VC1 count=5 -> all outputs return to reset values asynchronously, no credit pulse follows; traffic resumes normally after deassertion.
